// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared key codes, operator codes and scanner states for the calculator front end
package calc_pkg;

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b100;

    typedef enum logic [3:0] {
        KEY_0, KEY_1, KEY_2, KEY_3, KEY_4, KEY_5, KEY_6, KEY_7, KEY_8, KEY_9,
        KEY_A, KEY_B, KEY_C, KEY_D, KEY_STAR, KEY_HASH
    } key_code_t;

    typedef enum logic [2:0] {SCAN, DEBOUNCE, PRESENT, STROBE, RELEASE} scan_state_t;

    function automatic key_code_t key_lut(input logic [1:0] row, input logic [1:0] col);
        key_code_t k;
        case ({row, col})
            4'h0: k = KEY_1;    4'h1: k = KEY_2;    4'h2: k = KEY_3;    4'h3: k = KEY_A;
            4'h4: k = KEY_4;    4'h5: k = KEY_5;    4'h6: k = KEY_6;    4'h7: k = KEY_B;
            4'h8: k = KEY_7;    4'h9: k = KEY_8;    4'ha: k = KEY_9;    4'hb: k = KEY_C;
            4'hc: k = KEY_STAR; 4'hd: k = KEY_0;    4'he: k = KEY_HASH; default: k = KEY_D;
        endcase
        return k;
    endfunction

    // Index of the lowest active (0) row; only meaningful when exactly one bit is low.
    function automatic logic [1:0] low_index(input logic [3:0] rows);
        if (!rows[0])      return 2'd0;
        else if (!rows[1]) return 2'd1;
        else if (!rows[2]) return 2'd2;
        else               return 2'd3;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer, resets to all-ones (idle pulled-up level)
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad scanner/debouncer emitting one calculator event per press
module keypad_scanner
    import calc_pkg::*;
#(
    parameter int SETTLE_CYCLES   = 4,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic [3:0] row_sense,
    output logic [3:0] col_drive,
    output logic [3:0] keypad_input,
    output logic       read_input,
    output logic [2:0] operator_input,
    output logic       equal_input
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [3:0]  rs;
    scan_state_t state, state_d;
    logic [1:0]  idx, idx_d;
    logic [SW-1:0] settle_cnt, settle_d;
    logic [DW-1:0] deb_cnt, deb_d, deb_inc;
    logic [3:0]  pat_q, pat_d;
    key_code_t   key_q, key_d;
    logic [3:0]  keypad_d;
    logic        read_d, equal_d;
    logic [2:0]  op_d;

    sync_2ff #(.WIDTH(4)) u_row_sync (
        .clk   (clk),
        .rst_n (nRST),
        .d     (row_sense),
        .q     (rs)
    );

    assign col_drive = ~(4'b0001 << idx);
    assign deb_inc   = (deb_cnt == DW'(DEBOUNCE_CYCLES)) ? deb_cnt : deb_cnt + DW'(1);

    always_comb begin
        state_d  = state;
        idx_d    = idx;
        settle_d = settle_cnt;
        deb_d    = deb_cnt;
        pat_d    = pat_q;
        key_d    = key_q;
        keypad_d = keypad_input;
        read_d   = 1'b0;
        op_d     = 3'b000;
        equal_d  = 1'b0;
        case (state)
            SCAN: begin
                if (settle_cnt == SW'(SETTLE_CYCLES)) begin
                    settle_d = '0;
                    // Multiple rows low in one column is ambiguous, so it is treated as no key.
                    if ($countones(~rs) == 1) begin
                        pat_d   = rs;
                        key_d   = key_lut(low_index(rs), idx);
                        deb_d   = '0;
                        state_d = DEBOUNCE;
                    end else begin
                        idx_d = idx + 2'd1;
                    end
                end else begin
                    settle_d = settle_cnt + SW'(1);
                end
            end
            DEBOUNCE: begin
                if (rs == pat_q) begin
                    deb_d = deb_inc;
                    if (deb_inc == DW'(DEBOUNCE_CYCLES)) begin
                        deb_d   = '0;
                        state_d = PRESENT;
                    end
                end else begin
                    deb_d    = '0;
                    settle_d = '0;
                    state_d  = SCAN;
                end
            end
            PRESENT: begin
                // Digit is loaded a cycle ahead of read_input so it is already stable at the strobe.
                if (key_q <= KEY_9) keypad_d = 4'(key_q);
                state_d = STROBE;
            end
            STROBE: begin
                case (key_q)
                    KEY_A:             op_d    = OP_ADD;
                    KEY_B:             op_d    = OP_SUB;
                    KEY_C:             op_d    = OP_MUL;
                    KEY_D:             equal_d = 1'b1;
                    KEY_STAR, KEY_HASH: ;
                    default:           read_d  = 1'b1;
                endcase
                deb_d   = '0;
                state_d = RELEASE;
            end
            RELEASE: begin
                if (rs == 4'hf) begin
                    deb_d = deb_inc;
                    if (deb_inc == DW'(DEBOUNCE_CYCLES)) begin
                        deb_d    = '0;
                        settle_d = '0;
                        idx_d    = idx + 2'd1;
                        state_d  = SCAN;
                    end
                end else begin
                    deb_d = '0;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state          <= SCAN;
            idx            <= 2'd0;
            settle_cnt     <= '0;
            deb_cnt        <= '0;
            pat_q          <= 4'hf;
            key_q          <= KEY_0;
            keypad_input   <= 4'd0;
            read_input     <= 1'b0;
            operator_input <= 3'b000;
            equal_input    <= 1'b0;
        end else begin
            state          <= state_d;
            idx            <= idx_d;
            settle_cnt     <= settle_d;
            deb_cnt        <= deb_d;
            pat_q          <= pat_d;
            key_q          <= key_d;
            keypad_input   <= keypad_d;
            read_input     <= read_d;
            operator_input <= op_d;
            equal_input    <= equal_d;
        end
    end

endmodule
